// File: rtl/mandel_pkg.sv
// rtl/mandel_pkg.sv - shared frame geometry defaults, scheduler state enum, helpers
package mandel_pkg;

  // Default frame geometry and data widths for the Mandelbrot frame buffer
  localparam int H_RES_DEF    = 640;
  localparam int V_RES_DEF    = 480;
  localparam int ADDR_W_DEF   = 19;
  localparam int DATA_W_DEF   = 7;
  localparam int MAX_ITER_DEF = 127;

  // Pixel coordinate width carried on the job interface
  localparam int COORD_W = 10;

  // Number of pixels in a default frame
  localparam int FRAME_PIXELS_DEF = H_RES_DEF * V_RES_DEF;

  // Scheduler states; ST_CLEAR is only reachable when the clear pass is built in
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } sched_state_t;

  // Pixel count of an arbitrary frame geometry
  function automatic int frame_pixels(input int h, input int v);
    return h * v;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - raster-order x/y/address walker with clear, advance and last-pixel flag
module raster_counter
  import mandel_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               advance,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr,
  output logic               last_pixel
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_RES - 1);

  logic line_end;

  assign line_end   = (x == X_LAST);
  assign last_pixel = line_end && (y == Y_LAST);

  // Step through the frame; addr tracks y*H_RES+x by incrementing alongside x
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (clear) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (advance) begin
      if (last_pixel) begin
        x    <= '0;
        y    <= '0;
        addr <= '0;
      end else if (line_end) begin
        x    <= '0;
        y    <= y + 1'b1;
        addr <= addr + 1'b1;
      end else begin
        x    <= x + 1'b1;
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_write_scheduler.sv
// rtl/frame_write_scheduler.sv - start/busy/done frame pass issuing pixel jobs and writing counts to BRAM port A (optional FRAME_CLEAR_PASS_EN)
module frame_write_scheduler
  import mandel_pkg::*;
#(
  parameter int H_RES    = H_RES_DEF,
  parameter int V_RES    = V_RES_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_ITER = MAX_ITER_DEF
) (
  input  logic               CLK_100MHz,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               job_valid,
  input  logic               job_ready,
  output logic [COORD_W-1:0] job_x,
  output logic [COORD_W-1:0] job_y,
  input  logic               res_valid,
  input  logic [DATA_W-1:0]  res_iter,
  output logic               bram_we,
  output logic [ADDR_W-1:0]  bram_addr,
  output logic [DATA_W-1:0]  bram_din,
  output logic [7:0]         frame_count
);

  localparam logic [DATA_W-1:0] MAX_V = DATA_W'(MAX_ITER);

  sched_state_t        state;
  logic                cnt_clear;
  logic                cnt_advance;
  logic                last_pixel;
  logic [COORD_W-1:0]  pix_x;
  logic [COORD_W-1:0]  pix_y;
  logic [ADDR_W-1:0]   pix_addr;
  logic [DATA_W-1:0]   res_sat;

  raster_counter #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_raster (
    .clk        (CLK_100MHz),
    .rst        (reset),
    .clear      (cnt_clear),
    .advance    (cnt_advance),
    .x          (pix_x),
    .y          (pix_y),
    .addr       (pix_addr),
    .last_pixel (last_pixel)
  );

  // Counter registers are already flops, so the job coordinates and write
  // address come straight from them; they only move on advance/clear.
  assign job_x     = pix_x;
  assign job_y     = pix_y;
  assign bram_addr = pix_addr;

  assign res_sat = (res_iter > MAX_V) ? MAX_V : res_iter;

  // Counter control: restart at pass start, step once per written pixel
  always_comb begin
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    case (state)
      ST_IDLE:  cnt_clear = start;
`ifdef FRAME_CLEAR_PASS_EN
      ST_CLEAR: begin
        if (last_pixel) cnt_clear   = 1'b1;
        else            cnt_advance = 1'b1;
      end
`endif
      ST_WRITE: cnt_advance = 1'b1;
      default:  ;
    endcase
  end

  // Pass sequencer with registered handshake, write and status outputs
  always_ff @(posedge CLK_100MHz or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      job_valid   <= 1'b0;
      bram_we     <= 1'b0;
      bram_din    <= '0;
      frame_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
`ifdef FRAME_CLEAR_PASS_EN
            state    <= ST_CLEAR;
            bram_we  <= 1'b1;
            bram_din <= '0;
`else
            state     <= ST_ISSUE;
            job_valid <= 1'b1;
`endif
          end
        end
`ifdef FRAME_CLEAR_PASS_EN
        ST_CLEAR: begin
          if (last_pixel) begin
            state     <= ST_ISSUE;
            bram_we   <= 1'b0;
            job_valid <= 1'b1;
          end
        end
`endif
        ST_ISSUE: begin
          if (job_valid && job_ready) begin
            job_valid <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (res_valid) begin
            bram_we  <= 1'b1;
            bram_din <= res_sat;
            state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          bram_we <= 1'b0;
          if (last_pixel) begin
            state       <= ST_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            frame_count <= frame_count + 1'b1;
          end else begin
            state     <= ST_ISSUE;
            job_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          job_valid <= 1'b0;
          bram_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_write_scheduler.sv
// tb/tb_frame_write_scheduler.sv - randomized self-checking bench for frame_write_scheduler
module tb_frame_write_scheduler;

  localparam int H    = 4;
  localparam int V    = 3;
  localparam int NPIX = H * V;
  localparam int AW   = 19;
  localparam int DW   = 7;
  localparam int MAXI = 100;
`ifdef FRAME_CLEAR_PASS_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, job_valid, job_ready, res_valid, bram_we;
  logic [9:0]    job_x, job_y;
  logic [DW-1:0] res_iter;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [7:0]    frame_count;

  frame_write_scheduler #(
    .H_RES(H), .V_RES(V), .ADDR_W(AW), .DATA_W(DW), .MAX_ITER(MAXI)
  ) dut (
    .CLK_100MHz (clk),
    .reset      (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_x      (job_x),
    .job_y      (job_y),
    .res_valid  (res_valid),
    .res_iter   (res_iter),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int din;
    int cyc;
  } wr_t;

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  wr_t wq[$];
  int  jx_q[$];
  int  jy_q[$];
  int  val_tab[NPIX];

  // engine behaviour knobs
  int  stall_n   = 0;   // <0: random 0..3 stall cycles per job
  int  delay_max = 0;
  int  iter_mode = 0;   // 0: x+y, 1: random with frequent 127
  bit  spurious  = 1'b0;
  bit  eng_flush = 1'b1;
  int  viol      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM write and done monitor
  initial begin
    forever begin
      @(negedge clk);
      if (bram_we === 1'b1) wq.push_back('{int'(bram_addr), int'(bram_din), cyc});
      if (done === 1'b1) done_cnt++;
    end
  end

  // iteration engine model: one job at a time, optional stalls and result delay
  initial begin
    bit         pending = 1'b0;
    bit         holding = 1'b0;
    int         dly = 0;
    int         hold = 0;
    int         val = 0;
    logic [9:0] hx = '0;
    logic [9:0] hy = '0;
    job_ready = 1'b0;
    res_valid = 1'b0;
    res_iter  = '0;
    forever begin
      @(negedge clk);
      job_ready = 1'b0;
      res_valid = 1'b0;
      res_iter  = DW'($urandom_range(0, 127));
      if (eng_flush) begin
        pending = 1'b0;
        holding = 1'b0;
        hold    = 0;
      end else if (pending) begin
        if (dly == 0) begin
          res_valid = 1'b1;
          res_iter  = DW'(val);
          pending   = 1'b0;
        end else begin
          dly--;
        end
      end else begin
        if (spurious && $urandom_range(0, 1) == 1) res_valid = 1'b1;
        if (job_valid === 1'b1) begin
          if (holding && (job_x !== hx || job_y !== hy)) viol++;
          if (bram_we === 1'b1) viol++;
          if (!holding) begin
            holding = 1'b1;
            hx      = job_x;
            hy      = job_y;
            hold    = (stall_n < 0) ? int'($urandom_range(0, 3)) : stall_n;
          end
          if (hold == 0) begin
            job_ready = 1'b1;
            pending   = 1'b1;
            holding   = 1'b0;
            dly       = int'($urandom_range(0, delay_max));
            if (iter_mode == 0) val = int'(hx) + int'(hy);
            else val = ($urandom_range(0, 3) == 0) ? 127 : int'($urandom_range(0, 127));
            jx_q.push_back(int'(hx));
            jy_q.push_back(int'(hy));
            if (int'(hy) * H + int'(hx) < NPIX) val_tab[int'(hy) * H + int'(hx)] = val;
          end else begin
            hold--;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXI) ? MAXI : v;
  endfunction

  task automatic start_pass();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, done, 1);
  endtask

  // compare one pass of captured writes and jobs against the frame model
  task automatic check_pass(input int wb, input int jb, input bit timing);
    int  nclr;
    wr_t w;
    wr_t p;
    nclr = CLR ? NPIX : 0;
    check("write_count", wq.size() - wb, nclr + NPIX);
    check("job_count", jx_q.size() - jb, NPIX);
    if (wq.size() - wb >= nclr + NPIX) begin
      for (int k = 0; k < nclr; k++) begin
        w = wq[wb + k];
        check($sformatf("clr_addr[%0d]", k), w.addr, k);
        check($sformatf("clr_din[%0d]", k), w.din, 0);
        if (k > 0) begin
          p = wq[wb + k - 1];
          check($sformatf("clr_gap[%0d]", k), w.cyc - p.cyc, 1);
        end
      end
      for (int k = 0; k < NPIX; k++) begin
        w = wq[wb + nclr + k];
        check($sformatf("addr[%0d]", k), w.addr, k);
        check($sformatf("din[%0d]", k), w.din, sat(val_tab[k]));
        if (timing) begin
          check($sformatf("din_xy[%0d]", k), w.din, (k % H) + (k / H));
          if (k > 0) begin
            p = wq[wb + nclr + k - 1];
            check($sformatf("pix_gap[%0d]", k), w.cyc - p.cyc, 3);
          end
        end
      end
    end
    if (jx_q.size() - jb >= NPIX) begin
      for (int k = 0; k < NPIX; k++) begin
        check($sformatf("job_x[%0d]", k), jx_q[jb + k], k % H);
        check($sformatf("job_y[%0d]", k), jy_q[jb + k], k / H);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag, input int fc);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_job_valid"}, job_valid, 0);
    check({tag, "_bram_we"}, bram_we, 0);
    check({tag, "_bram_addr"}, bram_addr, 0);
    check({tag, "_frame_count"}, frame_count, fc);
  endtask

  initial begin
    int wb, jb, n, nwq, dc;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset", 0);
    check("reset_din", bram_din, 0);
    check("reset_job_x", job_x, 0);
    check("reset_job_y", job_y, 0);
    rst       = 1'b0;
    eng_flush = 1'b0;
    repeat (2) @(negedge clk);

    // pass 1: immediate engine, iter = x+y, minimum per-pixel cost
    iter_mode = 0; stall_n = 0; delay_max = 0; spurious = 1'b0;
    wb = wq.size(); jb = jx_q.size(); dc = done_cnt;
    start_pass();
    check("busy_after_start", busy, 1);
    wait_done("done_pass1");
    check("frame_count_1", frame_count, 1);
    check("busy_at_done", busy, 0);
    repeat (3) @(negedge clk);
    check("done_pulses_1", done_cnt - dc, 1);
    check("busy_idle_1", busy, 0);
    check_pass(wb, jb, 1'b1);

    // pass 2: 5-cycle stalls, delayed/saturating results, spurious strobes, start during busy
    iter_mode = 1; stall_n = 5; delay_max = 3; spurious = 1'b1; viol = 0;
    wb = wq.size(); jb = jx_q.size();
    start_pass();
    for (int i = 0; i < 4; i++) begin
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done("done_pass2");
    check("frame_count_2", frame_count, 2);
    check("stall_stability", viol, 0);
    check_pass(wb, jb, 1'b0);
    nwq = wq.size();
    repeat (10) @(negedge clk);
    check("no_restart_busy", busy, 0);
    check("no_restart_writes", wq.size(), nwq);

    // passes 3+4: start held high, second pass follows straight from IDLE
    stall_n = -1; delay_max = 2; viol = 0;
    wb = wq.size(); jb = jx_q.size();
    @(negedge clk);
    start = 1'b1;
    wait_done("done_pass3");
    check("frame_count_3", frame_count, 3);
    check_pass(wb, jb, 1'b0);
    wb = wq.size(); jb = jx_q.size();
    n = 0;
    while (busy !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("restart_busy", busy, 1);
    start = 1'b0;
    wait_done("done_pass4");
    check("frame_count_4", frame_count, 4);
    check("stall_stability_b2b", viol, 0);
    check_pass(wb, jb, 1'b0);
    repeat (3) @(negedge clk);

    // reset after the 5th result write abandons the pass
    wb = wq.size();
    start_pass();
    n = 0;
    while (wq.size() < wb + (CLR ? NPIX : 0) + 5 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("reached_5th_write", wq.size() >= wb + (CLR ? NPIX : 0) + 5, 1);
    rst       = 1'b1;
    eng_flush = 1'b1;
    #1;
    check_idle_outputs("midreset", 0);
    nwq = wq.size();
    repeat (4) @(negedge clk);
    check("midreset_no_writes", wq.size(), nwq);
    rst       = 1'b0;
    eng_flush = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("post_reset", 0);
    wb = wq.size(); jb = jx_q.size();
    start_pass();
    wait_done("done_after_reset");
    check("frame_count_after_reset", frame_count, 1);
    check_pass(wb, jb, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
